regdeps_scoreboard: RTL

Parametrised successor to the decode-stage GPR scoreboard. It keeps an N-bit outstanding-writer refcount per register and accepts a configurable number of issue (get) and writeback (put) ports. It also has a configurable number of operand-read check ports with bypass qualifiers. New over the fixed 32x2-bit version:
- write-saturation stall instead of a simulation-only fatal;
- sticky overflow/underflow error flags;
- a running total of outstanding writes;
- a registered per-register busy vector.
It sits beside decode and gates issue.

---
 rtl/regdeps_scoreboard_if.sv | 40 ++++
 rtl/regdeps_scoreboard.sv | 129 ++++++++++++
 2 files changed

// File: rtl/regdeps_scoreboard_if.sv
// Decode-side bundle for the register dependency scoreboard: issue/writeback
// updates, operand and saturation checks in; stalls, busy map and error flags out.
interface regdeps_scoreboard_if #(
    parameter int NREGS = 32,
    parameter int RN_W  = 5,
    parameter int NGET  = 2,
    parameter int NPUT  = 2,
    parameter int NRD   = 3,
    parameter int TOT_W = 7
);
    logic [NGET-1:0]      get_v;
    logic [NGET*RN_W-1:0] get_name;
    logic [NPUT-1:0]      put_v;
    logic [NPUT*RN_W-1:0] put_name;
    logic [NRD-1:0]       rd_v;
    logic [NRD*RN_W-1:0]  rd_name;
    logic [NRD-1:0]       rd_bypassed;
    logic [NGET-1:0]      wr_chk_v;
    logic [NGET*RN_W-1:0] wr_chk_name;
    logic                 flush;
    logic                 err_clr;
    logic                 stall_raw;
    logic                 stall_sat;
    logic                 stall;
    logic [NREGS-1:0]     busy;
    logic [TOT_W-1:0]     outstanding;
    logic                 err_overflow;
    logic                 err_underflow;

    modport master (
        output get_v, get_name, put_v, put_name, rd_v, rd_name, rd_bypassed,
               wr_chk_v, wr_chk_name, flush, err_clr,
        input  stall_raw, stall_sat, stall, busy, outstanding, err_overflow, err_underflow
    );
    modport slave (
        input  get_v, get_name, put_v, put_name, rd_v, rd_name, rd_bypassed,
               wr_chk_v, wr_chk_name, flush, err_clr,
        output stall_raw, stall_sat, stall, busy, outstanding, err_overflow, err_underflow
    );
endinterface

// File: rtl/regdeps_scoreboard.sv
// Per-register outstanding-writer refcounts with clamped update, RAW and
// write-saturation stall generation, busy map and running outstanding total.
module regdeps_cell #(
    parameter int unsigned REG_ID = 0,
    parameter int RN_W  = 5,
    parameter int CNT_W = 2,
    parameter int NGET  = 2,
    parameter int NPUT  = 2
) (
    input  logic [NGET-1:0]      get_v,
    input  logic [NGET*RN_W-1:0] get_name,
    input  logic [NPUT-1:0]      put_v,
    input  logic [NPUT*RN_W-1:0] put_name,
    input  logic [NGET-1:0]      wr_chk_v,
    input  logic [NGET*RN_W-1:0] wr_chk_name,
    input  logic [CNT_W-1:0]     cnt,
    output logic [CNT_W-1:0]     nxt,
    output logic                 ovf,
    output logic                 unf,
    output logic                 sat
);
    // Signed headroom covers cnt+NGET on top and -NPUT below zero.
    localparam int S_W = CNT_W + $clog2(NGET + NPUT + 1) + 1;
    localparam logic [RN_W-1:0]       ID   = RN_W'(REG_ID);
    localparam logic signed [S_W-1:0] MAXC = S_W'((1 << CNT_W) - 1);
    localparam logic signed [S_W-1:0] ONE  = S_W'(1);

    logic signed [S_W-1:0] inc, dec, chk, base, raw;

    always_comb begin
        inc = '0;
        dec = '0;
        chk = '0;
        for (int i = 0; i < NGET; i++) begin
            if (get_v[i] && get_name[i*RN_W +: RN_W] == ID) inc = inc + ONE;
            if (wr_chk_v[i] && wr_chk_name[i*RN_W +: RN_W] == ID) chk = chk + ONE;
        end
        for (int j = 0; j < NPUT; j++)
            if (put_v[j] && put_name[j*RN_W +: RN_W] == ID) dec = dec + ONE;
        base = S_W'(cnt);
        raw  = base + inc - dec;
        ovf  = raw > MAXC;
        unf  = raw[S_W-1];
        sat  = (base + chk) > MAXC;
        if (ovf)      nxt = MAXC[CNT_W-1:0];
        else if (unf) nxt = '0;
        else          nxt = raw[CNT_W-1:0];
    end
endmodule

module regdeps_scoreboard #(
    parameter int NREGS = 32,
    parameter int RN_W  = 5,
    parameter int CNT_W = 2,
    parameter int NGET  = 2,
    parameter int NPUT  = 2,
    parameter int NRD   = 3,
    parameter int TOT_W = 7
) (
    input logic clk,
    input logic reset_n,
    regdeps_scoreboard_if.slave sb
);
    logic [NREGS-1:0][CNT_W-1:0] cnt, nxt;
    logic [NREGS-1:0]            ovf, unf, sat, busy_nxt, busy_q;
    logic [TOT_W-1:0]            tot_nxt, tot_q;
    logic                        raw_hit, err_ovf_q, err_unf_q;

    // Names outside 0..NREGS-1 match no cell, so they drop out everywhere.
    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        regdeps_cell #(
            .REG_ID(g), .RN_W(RN_W), .CNT_W(CNT_W), .NGET(NGET), .NPUT(NPUT)
        ) u_cell (
            .get_v(sb.get_v), .get_name(sb.get_name),
            .put_v(sb.put_v), .put_name(sb.put_name),
            .wr_chk_v(sb.wr_chk_v), .wr_chk_name(sb.wr_chk_name),
            .cnt(cnt[g]), .nxt(nxt[g]), .ovf(ovf[g]), .unf(unf[g]), .sat(sat[g])
        );
    end

    always_comb begin
        tot_nxt  = '0;
        busy_nxt = '0;
        for (int r = 0; r < NREGS; r++) begin
            tot_nxt     = tot_nxt + TOT_W'(nxt[r]);
            busy_nxt[r] = (nxt[r] != '0);
        end
    end

    // RAW looks only at registered counts; same-cycle writebacks do not help.
    always_comb begin
        raw_hit = 1'b0;
        for (int k = 0; k < NRD; k++)
            if (sb.rd_v[k] && !sb.rd_bypassed[k])
                for (int r = 0; r < NREGS; r++)
                    if (sb.rd_name[k*RN_W +: RN_W] == RN_W'(r) && cnt[r] != '0)
                        raw_hit = 1'b1;
    end

    assign sb.stall_raw     = raw_hit;
    assign sb.stall_sat     = |sat;
    assign sb.stall         = raw_hit | (|sat);
    assign sb.busy          = busy_q;
    assign sb.outstanding   = tot_q;
    assign sb.err_overflow  = err_ovf_q;
    assign sb.err_underflow = err_unf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            busy_q    <= '0;
            tot_q     <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else if (sb.flush) begin
            cnt       <= '0;
            busy_q    <= '0;
            tot_q     <= '0;
            err_ovf_q <= err_ovf_q & ~sb.err_clr;
            err_unf_q <= err_unf_q & ~sb.err_clr;
        end else begin
            cnt       <= nxt;
            busy_q    <= busy_nxt;
            tot_q     <= tot_nxt;
            err_ovf_q <= (|ovf) | (err_ovf_q & ~sb.err_clr);
            err_unf_q <= (|unf) | (err_unf_q & ~sb.err_clr);
        end
    end
endmodule
